// File: rtl/saw_pkg.sv
// Shared types and defaults for the stop-and-wait ARQ sender (saw_tx_link).
package saw_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'b000,
      ST_READY    = 3'b001,
      ST_SEND     = 3'b010,
      ST_WAIT_ACK = 3'b011,
      ST_FAIL     = 3'b100
   } state_t;

   localparam int DEF_DW        = 8;
   localparam int DEF_TIMEOUT   = 8;
   localparam int DEF_MAX_RETRY = 3;
   localparam int STATS_W       = 16;

endpackage

// File: rtl/saw_timeout_timer.sv
// ACK timeout counter: counts enabled cycles, flags the last cycle of the window.
module saw_timeout_timer
   import saw_pkg::*;
#(
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] count;

   // NOTE: sequential state is written with <= so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + CW'(1);
      end
   end

   assign expired = (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/saw_tx_link.sv
// Stop-and-wait ARQ data sender with 1-bit sequence numbers and bounded retransmission.
// Define SAW_TX_STATS_EN to add saturating seg_count / retx_count outputs.
module saw_tx_link
   import saw_pkg::*;
#(
   parameter int DW        = DEF_DW,
   parameter int TIMEOUT   = DEF_TIMEOUT,
   parameter int MAX_RETRY = DEF_MAX_RETRY
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          conn_est,
   input  logic          tx_valid,
   input  logic [DW-1:0] tx_data,
   output logic          tx_ready,
   output logic          seg_valid,
   output logic          seg_seq,
   output logic [DW-1:0] seg_data,
   input  logic          ack_valid,
   input  logic          ack_seq,
   output logic          tx_done,
   output logic          retry_err,
   output logic [2:0]    state
`ifdef SAW_TX_STATS_EN
   ,
   output logic [STATS_W-1:0] seg_count,
   output logic [STATS_W-1:0] retx_count
`endif
);

   localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

   state_t        cur_state, nxt_state;
   logic          seq, nxt_seq;
   logic [RW-1:0] retry_cnt, nxt_retry;
   logic [DW-1:0] data_buf, nxt_buf;
   logic          nxt_done;
   logic          expired;

   saw_timeout_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (cur_state != ST_WAIT_ACK),
      .enable  (cur_state == ST_WAIT_ACK),
      .expired (expired)
   );

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      nxt_state = cur_state;
      nxt_seq   = seq;
      nxt_retry = retry_cnt;
      nxt_buf   = data_buf;
      nxt_done  = 1'b0;

      case (cur_state)
         ST_IDLE: begin
            if (conn_est) nxt_state = ST_READY;
         end
         ST_READY: begin
            if (tx_valid && tx_ready) begin
               nxt_buf   = tx_data;
               nxt_state = ST_SEND;
            end
         end
         ST_SEND: begin
            nxt_state = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            // A matching ACK on the timeout cycle still completes the transfer.
            if (ack_valid && (ack_seq == seq)) begin
               nxt_done  = 1'b1;
               nxt_seq   = ~seq;
               nxt_retry = '0;
               nxt_state = ST_READY;
            end else if (expired) begin
               if (retry_cnt < RW'(MAX_RETRY)) begin
                  nxt_retry = retry_cnt + RW'(1);
                  nxt_state = ST_SEND;
               end else begin
                  nxt_state = ST_FAIL;
               end
            end
         end
         ST_FAIL: ;
         default: nxt_state = ST_IDLE;
      endcase

      // Losing the connection abandons any transfer and restarts sequencing at 0.
      if (!conn_est) begin
         nxt_state = ST_IDLE;
         nxt_seq   = 1'b0;
         nxt_retry = '0;
         nxt_buf   = '0;
         nxt_done  = 1'b0;
      end
   end

   // NOTE: the payload buffer is a plain register, so it is reset like the rest of the state.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state <= ST_IDLE;
         seq       <= 1'b0;
         retry_cnt <= '0;
         data_buf  <= '0;
         tx_ready  <= 1'b0;
         seg_valid <= 1'b0;
         seg_seq   <= 1'b0;
         seg_data  <= '0;
         tx_done   <= 1'b0;
         retry_err <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         seq       <= nxt_seq;
         retry_cnt <= nxt_retry;
         data_buf  <= nxt_buf;
         tx_ready  <= (nxt_state == ST_READY);
         seg_valid <= (nxt_state == ST_SEND);
         seg_seq   <= (nxt_state == ST_SEND) && nxt_seq;
         seg_data  <= (nxt_state == ST_SEND) ? nxt_buf : '0;
         tx_done   <= nxt_done;
         retry_err <= (nxt_state == ST_FAIL);
      end
   end

   assign state = cur_state;

`ifdef SAW_TX_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         seg_count  <= '0;
         retx_count <= '0;
      end else begin
         if ((nxt_state == ST_SEND) && (seg_count != '1)) begin
            seg_count <= seg_count + STATS_W'(1);
         end
         if ((cur_state == ST_WAIT_ACK) && (nxt_state == ST_SEND) && (retx_count != '1)) begin
            retx_count <= retx_count + STATS_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_saw_tx_link.sv
// Scoreboard bench for saw_tx_link: directed stimulus queues expected segments and tx_done pulses.
module tb_saw_tx_link;

   logic       clk = 1'b0;
   logic       reset;
   logic       conn_est;
   logic       tx_valid;
   logic [7:0] tx_data;
   logic       tx_ready;
   logic       seg_valid;
   logic       seg_seq;
   logic [7:0] seg_data;
   logic       ack_valid;
   logic       ack_seq;
   logic       tx_done;
   logic       retry_err;
   logic [2:0] state;
`ifdef SAW_TX_STATS_EN
   logic [15:0] seg_count;
   logic [15:0] retx_count;
`endif

   int cyc    = 0;
   int checks = 0;
   int errors = 0;

   typedef struct {
      int         cyc;
      logic       seq;
      logic [7:0] data;
   } seg_exp_t;

   seg_exp_t seg_q[$];
   int       done_q[$];

   saw_tx_link #(
      .DW        (8),
      .TIMEOUT   (8),
      .MAX_RETRY (3)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .conn_est  (conn_est),
      .tx_valid  (tx_valid),
      .tx_data   (tx_data),
      .tx_ready  (tx_ready),
      .seg_valid (seg_valid),
      .seg_seq   (seg_seq),
      .seg_data  (seg_data),
      .ack_valid (ack_valid),
      .ack_seq   (ack_seq),
      .tx_done   (tx_done),
      .retry_err (retry_err),
      .state     (state)
`ifdef SAW_TX_STATS_EN
      ,
      .seg_count  (seg_count),
      .retx_count (retx_count)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d actual %0h required %0h", name, cyc, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic go_to(input int c);
      while (cyc < c) tick();
   endtask

   function automatic void push_seg(input int c, input logic s, input logic [7:0] d);
      seg_exp_t e;
      e.cyc  = c;
      e.seq  = s;
      e.data = d;
      seg_q.push_back(e);
   endfunction

   // Offers d until accepted; returns the accept cycle and queues the segment one cycle later.
   task automatic accept(input logic [7:0] d, input logic exp_seq, output int c);
      int n = 0;
      tx_data  = d;
      tx_valid = 1'b1;
      while (!tx_ready && n < 50) begin
         tick();
         n++;
      end
      check("accept_ready", tx_ready, 1);
      c = cyc;
      push_seg(c + 1, exp_seq, d);
      tick();
      tx_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      seg_exp_t e;
      int       dc;
      if (!reset && seg_valid) begin
         if (seg_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL seg_unexpected cycle %0d actual seq %0b data %0h required none", cyc, seg_seq, seg_data);
         end else begin
            e = seg_q.pop_front();
            check("seg_cycle", cyc, e.cyc);
            check("seg_seq", seg_seq, e.seq);
            check("seg_data", seg_data, e.data);
         end
      end
      if (!reset && tx_done) begin
         if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done_unexpected cycle %0d actual pulse required none", cyc);
         end else begin
            dc = done_q.pop_front();
            check("done_cycle", cyc, dc);
         end
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, s, m, a, b, f;
      reset     = 1'b1;
      conn_est  = 1'b0;
      tx_valid  = 1'b0;
      tx_data   = 8'h00;
      ack_valid = 1'b0;
      ack_seq   = 1'b0;
      repeat (3) tick();
      reset = 1'b0;

      // reset state
      check("rst_state", state, 3'b000);
      check("rst_tx_ready", tx_ready, 0);
      check("rst_seg_valid", seg_valid, 0);
      check("rst_seg_data", {seg_seq, seg_data}, 0);
      check("rst_tx_done", tx_done, 0);
      check("rst_retry_err", retry_err, 0);

      conn_est = 1'b1;
      tick();
      check("ready_state", state, 3'b001);
      check("ready_tx_ready", tx_ready, 1);

      // normal transfer, ACK two cycles after the segment
      accept(8'hA5, 1'b0, n);
      check("send_state", state, 3'b010);
      go_to(n + 3);
      ack_valid = 1'b1;
      ack_seq   = 1'b0;
      done_q.push_back(n + 4);
      tick();
      ack_valid = 1'b0;
      check("normal_state", state, 3'b001);
      check("normal_tx_ready", tx_ready, 1);

      // stale ACK ignored, matching ACK on the timeout cycle wins
      accept(8'hC3, 1'b1, s);
      go_to(s + 4);
      ack_valid = 1'b1;
      ack_seq   = 1'b0;
      tick();
      ack_valid = 1'b0;
      check("stale_state", state, 3'b011);
      go_to(s + 9);
      ack_valid = 1'b1;
      ack_seq   = 1'b1;
      done_q.push_back(s + 10);
      tick();
      ack_valid = 1'b0;
      check("stale_done_state", state, 3'b001);
      go_to(s + 13);

      // two retransmits, payload input changes must not leak into segments
      accept(8'h3C, 1'b0, m);
      tx_data = 8'hFF;
      push_seg(m + 10, 1'b0, 8'h3C);
      push_seg(m + 19, 1'b0, 8'h3C);
      go_to(m + 21);
      ack_valid = 1'b1;
      ack_seq   = 1'b0;
      done_q.push_back(m + 22);
      tick();
      ack_valid = 1'b0;

      // abort in WAIT_ACK
      accept(8'h77, 1'b1, a);
      go_to(a + 4);
      conn_est = 1'b0;
      tick();
      check("abort_state", state, 3'b000);
      check("abort_tx_ready", tx_ready, 0);
      go_to(a + 15);
      check("abort_idle_hold", state, 3'b000);
      conn_est = 1'b1;
      tick();

      // back-to-back with tx_valid held; first segment after reconnect has seq 0
      b        = cyc;
      tx_valid = 1'b1;
      tx_data  = 8'h11;
      push_seg(b + 1, 1'b0, 8'h11);
      tick();
      tx_data = 8'h22;
      go_to(b + 3);
      ack_valid = 1'b1;
      ack_seq   = 1'b0;
      done_q.push_back(b + 4);
      tick();
      ack_valid = 1'b0;
      check("b2b_ready1", tx_ready, 1);
      push_seg(b + 5, 1'b1, 8'h22);
      tick();
      tx_data = 8'h33;
      go_to(b + 7);
      ack_valid = 1'b1;
      ack_seq   = 1'b1;
      done_q.push_back(b + 8);
      tick();
      ack_valid = 1'b0;
      check("b2b_ready2", tx_ready, 1);
      push_seg(b + 9, 1'b0, 8'h33);
      tick();
      tx_valid = 1'b0;
      go_to(b + 11);
      ack_valid = 1'b1;
      ack_seq   = 1'b0;
      done_q.push_back(b + 12);
      tick();
      ack_valid = 1'b0;

      // failure after MAX_RETRY retransmits
      accept(8'h5A, 1'b1, f);
      push_seg(f + 10, 1'b1, 8'h5A);
      push_seg(f + 19, 1'b1, 8'h5A);
      push_seg(f + 28, 1'b1, 8'h5A);
      go_to(f + 36);
      check("pre_fail_err", retry_err, 0);
      tick();
      check("fail_state", state, 3'b100);
      check("fail_err", retry_err, 1);
      check("fail_tx_ready", tx_ready, 0);
      go_to(f + 45);
      check("fail_hold_state", state, 3'b100);
      check("fail_hold_err", retry_err, 1);
      conn_est = 1'b0;
      tick();
      check("fail_exit_state", state, 3'b000);
      check("fail_exit_err", retry_err, 0);

      repeat (3) tick();
      check("seg_q_drained", seg_q.size(), 0);
      check("done_q_drained", done_q.size(), 0);
`ifdef SAW_TX_STATS_EN
      check("seg_count", seg_count, 13);
      check("retx_count", retx_count, 5);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
